// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, AXI encodings
// and default fetch parameters.
package ifu_fetch_pkg;

   localparam int CPU_WIDTH_DEFAULT = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      idle_t,
      req_t,
      resp_t,
      out_t
   } fetch_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: single-outstanding AXI read master toward the
// instruction cache, presenting {pc, inst} to decode with valid/ready.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter int CPU_WIDTH = CPU_WIDTH_DEFAULT,
   parameter logic [CPU_WIDTH-1:0] RESET_PC = CPU_WIDTH'(RESET_PC_DEFAULT),
   parameter logic [3:0] FETCH_ID = 4'h0
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_redirect_valid,
   input  logic [CPU_WIDTH-1:0] i_redirect_pc,
   output logic                 o_inst_valid,
   input  logic                 i_inst_ready,
   output logic [31:0]          o_inst,
   output logic [CPU_WIDTH-1:0] o_pc,
   output logic                 o_fetch_err,
   input  logic                 ifu_arready,
   output logic                 ifu_arvalid,
   output logic [CPU_WIDTH-1:0] ifu_araddr,
   output logic [3:0]           ifu_arid,
   output logic [7:0]           ifu_arlen,
   output logic [2:0]           ifu_arsize,
   output logic [1:0]           ifu_arburst,
   input  logic                 ifu_rvalid,
   output logic                 ifu_rready,
   input  logic [CPU_WIDTH-1:0] ifu_rdata,
   input  logic [1:0]           ifu_rresp,
   input  logic                 ifu_rlast,
   input  logic [3:0]           ifu_rid
);

   fetch_state_e         state;
   logic [CPU_WIDTH-1:0] pc;
   logic                 flush;
   logic [CPU_WIDTH-1:0] pc_plus4;
   logic [CPU_WIDTH-1:0] target_pc;
   logic                 unused_rid;

   assign ifu_arid    = FETCH_ID;
   assign ifu_arlen   = 8'd0;
   assign ifu_arsize  = AXI_SIZE_4B;
   assign ifu_arburst = AXI_BURST_INCR;
   assign unused_rid  = ^ifu_rid;

   assign pc_plus4  = pc + CPU_WIDTH'(4);
   assign target_pc = i_redirect_valid ? i_redirect_pc : pc;

   // A redirect never retracts an AR already on the bus; instead the flush flag
   // marks the single in-flight response to be dropped, and the refetch uses
   // whatever pc the latest redirect left behind.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= idle_t;
         pc           <= RESET_PC;
         flush        <= 1'b0;
         ifu_arvalid  <= 1'b0;
         ifu_araddr   <= RESET_PC;
         ifu_rready   <= 1'b0;
         o_inst_valid <= 1'b0;
         o_inst       <= 32'd0;
         o_pc         <= RESET_PC;
         o_fetch_err  <= 1'b0;
      end else begin
         case (state)
            idle_t: begin
               pc          <= target_pc;
               ifu_arvalid <= 1'b1;
               ifu_araddr  <= target_pc;
               state       <= req_t;
            end

            req_t: begin
               if (i_redirect_valid) begin
                  pc    <= i_redirect_pc;
                  flush <= 1'b1;
               end
               if (ifu_arvalid && ifu_arready) begin
                  ifu_arvalid <= 1'b0;
                  ifu_rready  <= 1'b1;
                  state       <= resp_t;
               end
            end

            resp_t: begin
               if (ifu_rvalid && ifu_rready && ifu_rlast) begin
                  ifu_rready <= 1'b0;
                  if (flush || i_redirect_valid) begin
                     flush       <= 1'b0;
                     pc          <= target_pc;
                     ifu_arvalid <= 1'b1;
                     ifu_araddr  <= target_pc;
                     state       <= req_t;
                  end else begin
                     o_inst       <= ifu_rdata[31:0];
                     o_pc         <= pc;
                     o_fetch_err  <= (ifu_rresp != AXI_RESP_OKAY);
                     o_inst_valid <= 1'b1;
                     state        <= out_t;
                  end
               end else if (i_redirect_valid) begin
                  pc    <= i_redirect_pc;
                  flush <= 1'b1;
               end
            end

            // A redirect wins over a simultaneous decode handshake for the next pc.
            out_t: begin
               if (i_redirect_valid) begin
                  o_inst_valid <= 1'b0;
                  pc           <= i_redirect_pc;
                  ifu_arvalid  <= 1'b1;
                  ifu_araddr   <= i_redirect_pc;
                  state        <= req_t;
               end else if (i_inst_ready) begin
                  o_inst_valid <= 1'b0;
                  pc           <= pc_plus4;
                  ifu_arvalid  <= 1'b1;
                  ifu_araddr   <= pc_plus4;
                  state        <= req_t;
               end
            end

            default: state <= idle_t;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a behavioural cache responder plus scoreboards
// of expected AR addresses and expected decode-side instructions.
module tb_ifu_fetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
   } fetch_exp_t;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_redirect_valid;
   logic [31:0] i_redirect_pc;
   logic        o_inst_valid;
   logic        i_inst_ready;
   logic [31:0] o_inst;
   logic [31:0] o_pc;
   logic        o_fetch_err;
   logic        ifu_arready;
   logic        ifu_arvalid;
   logic [31:0] ifu_araddr;
   logic [3:0]  ifu_arid;
   logic [7:0]  ifu_arlen;
   logic [2:0]  ifu_arsize;
   logic [1:0]  ifu_arburst;
   logic        ifu_rvalid;
   logic        ifu_rready;
   logic [31:0] ifu_rdata;
   logic [1:0]  ifu_rresp;
   logic        ifu_rlast;
   logic [3:0]  ifu_rid;

   int vectors = 0;
   int miscompares = 0;

   fetch_exp_t  exp_q[$];
   logic [31:0] ar_exp[$];
   logic [31:0] err_addr = 32'h0;
   logic [31:0] ar_addr_q = 32'h0;
   logic        ar_due = 1'b0;
   logic        beat_due = 1'b0;

   ifu_fetch #(
      .CPU_WIDTH(32),
      .RESET_PC(RST_PC),
      .FETCH_ID(4'h0)
   ) dut (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_redirect_valid(i_redirect_valid),
      .i_redirect_pc(i_redirect_pc),
      .o_inst_valid(o_inst_valid),
      .i_inst_ready(i_inst_ready),
      .o_inst(o_inst),
      .o_pc(o_pc),
      .o_fetch_err(o_fetch_err),
      .ifu_arready(ifu_arready),
      .ifu_arvalid(ifu_arvalid),
      .ifu_araddr(ifu_araddr),
      .ifu_arid(ifu_arid),
      .ifu_arlen(ifu_arlen),
      .ifu_arsize(ifu_arsize),
      .ifu_arburst(ifu_arburst),
      .ifu_rvalid(ifu_rvalid),
      .ifu_rready(ifu_rready),
      .ifu_rdata(ifu_rdata),
      .ifu_rresp(ifu_rresp),
      .ifu_rlast(ifu_rlast),
      .ifu_rid(ifu_rid)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == RST_PC) return 32'h0000_0413;
      return {a[11:0], 20'h00093};
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic apply_stimulus(input logic ready, input logic arready,
                                 input logic redir, input logic [31:0] rpc);
      @(posedge i_clk);
      #1;
      i_inst_ready     = ready;
      ifu_arready      = arready;
      i_redirect_valid = redir;
      i_redirect_pc    = rpc;
   endtask

   task automatic wait_inst_valid(input string tag);
      for (int i = 0; i < 40; i++) begin
         @(negedge i_clk);
         if (o_inst_valid) break;
      end
      check_output(tag, 32'(o_inst_valid), 32'd1);
   endtask

   task automatic push_fetch(input logic [31:0] pc, input logic err);
      fetch_exp_t e;
      e.pc   = pc;
      e.inst = mem_word(pc);
      e.err  = err;
      exp_q.push_back(e);
   endtask

   // Cache model: accepts AR on the negedge view, returns one beat a cycle later.
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         ifu_rvalid = 1'b0;
         ar_due     = 1'b0;
         beat_due   = 1'b0;
      end else begin
         if (beat_due) begin
            ifu_rvalid = 1'b0;
            beat_due   = 1'b0;
         end
         if (ar_due) begin
            ifu_rvalid = 1'b1;
            ifu_rdata  = mem_word(ar_addr_q);
            ifu_rresp  = (ar_addr_q == err_addr) ? 2'b10 : 2'b00;
            ar_due     = 1'b0;
         end
         if (ifu_rvalid && ifu_rready) beat_due = 1'b1;
         if (ifu_arvalid && ifu_arready) begin
            if (ar_exp.size() == 0) begin
               vectors++;
               miscompares++;
               $error("FAIL ar_unexpected observed=%h expected=none", ifu_araddr);
            end else begin
               ar_addr_q = ar_exp.pop_front();
               check_output("ar_addr", ifu_araddr, ar_addr_q);
               check_output("ar_len", 32'(ifu_arlen), 32'd0);
               check_output("ar_size", 32'(ifu_arsize), 32'd2);
               check_output("ar_burst", 32'(ifu_arburst), 32'd1);
               check_output("ar_id", 32'(ifu_arid), 32'd0);
               ar_due = 1'b1;
            end
         end
      end
   end

   // Decode-side monitor: every accepted instruction must match the scoreboard.
   always @(negedge i_clk) begin
      if (i_rst_n && o_inst_valid && i_inst_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL inst_unexpected observed=%h expected=none", o_pc);
         end else begin
            fetch_exp_t e;
            e = exp_q.pop_front();
            check_output("sb_pc", o_pc, e.pc);
            check_output("sb_inst", o_inst, e.inst);
            check_output("sb_err", 32'(o_fetch_err), 32'(e.err));
         end
      end
   end

   initial begin
      i_rst_n          = 1'b0;
      i_redirect_valid = 1'b0;
      i_redirect_pc    = 32'h0;
      i_inst_ready     = 1'b0;
      ifu_arready      = 1'b1;
      ifu_rvalid       = 1'b0;
      ifu_rdata        = 32'h0;
      ifu_rresp        = 2'b00;
      ifu_rlast        = 1'b1;
      ifu_rid          = 4'h0;

      // Reset values
      repeat (2) @(negedge i_clk);
      check_output("rst_arvalid", 32'(ifu_arvalid), 32'd0);
      check_output("rst_rready", 32'(ifu_rready), 32'd0);
      check_output("rst_inst_valid", 32'(o_inst_valid), 32'd0);
      check_output("rst_inst", o_inst, 32'd0);
      check_output("rst_err", 32'(o_fetch_err), 32'd0);
      check_output("rst_araddr", ifu_araddr, RST_PC);

      // First fetch from the reset vector
      $display("[TB] first fetch");
      ar_exp.push_back(RST_PC);
      push_fetch(RST_PC, 1'b0);
      @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      wait_inst_valid("t1_valid");
      check_output("t1_inst", o_inst, 32'h0000_0413);
      check_output("t1_pc", o_pc, RST_PC);
      check_output("t1_err", 32'(o_fetch_err), 32'd0);

      // Decode stalls: outputs hold, no new AR
      $display("[TB] decode stall");
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         check_output("t2_hold_valid", 32'(o_inst_valid), 32'd1);
         check_output("t2_hold_inst", o_inst, 32'h0000_0413);
         check_output("t2_hold_pc", o_pc, RST_PC);
         check_output("t2_no_ar", 32'(ifu_arvalid), 32'd0);
      end
      ar_exp.push_back(32'h8000_0004);
      push_fetch(32'h8000_0004, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      wait_inst_valid("t2_valid");
      check_output("t2_pc", o_pc, 32'h8000_0004);

      // Redirect while AR is stalled: address held, response dropped
      $display("[TB] redirect during stalled AR");
      ar_exp.push_back(32'h8000_0008);
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 32'h8000_0100);
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         check_output("t3_arvalid", 32'(ifu_arvalid), 32'd1);
         check_output("t3_araddr", ifu_araddr, 32'h8000_0008);
      end
      ar_exp.push_back(32'h8000_0100);
      push_fetch(32'h8000_0100, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      wait_inst_valid("t3_valid");
      check_output("t3_pc", o_pc, 32'h8000_0100);

      // Redirect coinciding with decode handshake
      $display("[TB] redirect with ready in out_t");
      ar_exp.push_back(32'h8000_0200);
      push_fetch(32'h8000_0200, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b1, 32'h8000_0200);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      wait_inst_valid("t4_valid");
      check_output("t4_pc", o_pc, 32'h8000_0200);

      // Error response still delivers, then fetch continues at pc+4
      $display("[TB] fetch error");
      err_addr = 32'h8000_0204;
      ar_exp.push_back(32'h8000_0204);
      push_fetch(32'h8000_0204, 1'b1);
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      wait_inst_valid("t5_valid");
      check_output("t5_err", 32'(o_fetch_err), 32'd1);
      ar_exp.push_back(32'h8000_0208);
      push_fetch(32'h8000_0208, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      wait_inst_valid("t5_next_valid");
      check_output("t5_next_err", 32'(o_fetch_err), 32'd0);
      check_output("t5_next_pc", o_pc, 32'h8000_0208);

      // Redirect landing on the same cycle as the R beat
      $display("[TB] redirect with R beat");
      ar_exp.push_back(32'h8000_020C);
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      ar_exp.push_back(32'h8000_0300);
      push_fetch(32'h8000_0300, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b1, 32'h8000_0300);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      wait_inst_valid("t5b_valid");
      check_output("t5b_pc", o_pc, 32'h8000_0300);

      // Asynchronous reset in the middle of a response wait
      $display("[TB] async reset in resp_t");
      ar_exp.push_back(32'h8000_0304);
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t6_in_resp", 32'(ifu_rready), 32'd1);
      #2 i_rst_n = 1'b0;
      #1;
      check_output("t6_arvalid", 32'(ifu_arvalid), 32'd0);
      check_output("t6_rready", 32'(ifu_rready), 32'd0);
      check_output("t6_inst_valid", 32'(o_inst_valid), 32'd0);
      check_output("t6_inst", o_inst, 32'd0);
      check_output("t6_err", 32'(o_fetch_err), 32'd0);
      check_output("t6_araddr", ifu_araddr, RST_PC);
      err_addr = 32'h0;
      ar_exp.push_back(RST_PC);
      push_fetch(RST_PC, 1'b0);
      repeat (2) @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      wait_inst_valid("t6_valid");
      check_output("t6_pc", o_pc, RST_PC);
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
      repeat (3) @(negedge i_clk);
      check_output("drain_inst_q", 32'(exp_q.size()), 32'd0);
      check_output("drain_ar_q", 32'(ar_exp.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
